decimal_entry: RTL and testbench

Upstream front end of the Decimal2Binary datapath. Takes debounced digit-key and control-key levels, builds a decimal number of up to three digits (0–255), and presents it as an 8-bit binary value. `number` drives the `number` input of the display FSM. The block handles edge detection, digit stacking, backspace, range checking and commit; it does no display scanning.

---
 rtl/decimal_entry_if.sv | 24 ++
 rtl/decimal_entry.sv | 130 +++++++++++++
 tb/tb_decimal_entry.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/decimal_entry_if.sv
// Key levels in, entered value out, between the keypad front end and the display FSM.
// The keypad side (master) drives key levels; the entry block (slave) returns the value.
interface decimal_entry_if;
    logic [3:0]  digit;
    logic        digit_key;
    logic        back_key;
    logic        enter_key;
    logic        clear_key;
    logic [7:0]  number;
    logic [11:0] bcd;
    logic [1:0]  count;
    logic        valid;
    logic        err;

    modport master (
        output digit, digit_key, back_key, enter_key, clear_key,
        input  number, bcd, count, valid, err
    );

    modport slave (
        input  digit, digit_key, back_key, enter_key, clear_key,
        output number, bcd, count, valid, err
    );
endinterface

// File: rtl/decimal_entry.sv
// Builds a 0-255 decimal entry from debounced key levels; outputs binary, BCD, digit count.
// Latency: 1 clock from a key level rising to updated outputs; err pulses for one cycle.
// No backpressure: every key edge is consumed the cycle it is seen, rejects flagged on err.
module decimal_entry #(
    parameter int MAX_DIGITS = 3
) (
    input  logic             clk,
    input  logic             reset,
    decimal_entry_if.slave   bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ENTRY = 2'd1,
        SHOW  = 2'd2
    } state_t;

    state_t     state, state_n;
    logic       digit_q, back_q, enter_q, clear_q;
    logic [3:0] d2, d1, d0;
    logic [3:0] d2_n, d1_n, d0_n;
    logic [1:0] cnt, cnt_n;
    logic [7:0] num, num_n;
    logic       err_r, err_n;
    logic       ev_digit, ev_back, ev_enter, ev_clear;
    logic [9:0] cand;

    assign ev_digit = bus.digit_key & ~digit_q;
    assign ev_back  = bus.back_key  & ~back_q;
    assign ev_enter = bus.enter_key & ~enter_q;
    assign ev_clear = bus.clear_key & ~clear_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            digit_q <= 1'b0;
            back_q  <= 1'b0;
            enter_q <= 1'b0;
            clear_q <= 1'b0;
            state   <= EMPTY;
            d2      <= 4'd0;
            d1      <= 4'd0;
            d0      <= 4'd0;
            cnt     <= 2'd0;
            num     <= 8'd0;
            err_r   <= 1'b0;
        end else begin
            digit_q <= bus.digit_key;
            back_q  <= bus.back_key;
            enter_q <= bus.enter_key;
            clear_q <= bus.clear_key;
            state   <= state_n;
            d2      <= d2_n;
            d1      <= d1_n;
            d0      <= d0_n;
            cnt     <= cnt_n;
            num     <= num_n;
            err_r   <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        d2_n    = d2;
        d1_n    = d1;
        d0_n    = d0;
        cnt_n   = cnt;
        err_n   = 1'b0;
        // Only meaningful below the digit limit, where value <= 99 keeps it in 10 bits.
        cand    = 10'(num) * 10'd10 + 10'(bus.digit);

        if (ev_clear) begin
            d2_n    = 4'd0;
            d1_n    = 4'd0;
            d0_n    = 4'd0;
            cnt_n   = 2'd0;
            state_n = EMPTY;
        end else if (ev_enter) begin
            case (state)
                ENTRY:   state_n = SHOW;
                EMPTY:   err_n   = 1'b1;
                default: ;
            endcase
        end else if (ev_back) begin
            case (state)
                ENTRY: begin
                    d0_n  = d1;
                    d1_n  = d2;
                    d2_n  = 4'd0;
                    cnt_n = cnt - 2'd1;
                    if (cnt == 2'd1)
                        state_n = EMPTY;
                end
                EMPTY:   err_n   = 1'b1;
                SHOW:    state_n = ENTRY;
                default: ;
            endcase
        end else if (ev_digit) begin
            if (bus.digit > 4'd9) begin
                err_n = 1'b1;
            end else if (state == SHOW) begin
                // A digit after commit starts a fresh entry.
                d2_n    = 4'd0;
                d1_n    = 4'd0;
                d0_n    = bus.digit;
                cnt_n   = 2'd1;
                state_n = ENTRY;
            end else if (cnt == 2'(MAX_DIGITS)) begin
                err_n = 1'b1;
            end else if (cand > 10'd255) begin
                err_n = 1'b1;
            end else begin
                d2_n    = d1;
                d1_n    = d0;
                d0_n    = bus.digit;
                cnt_n   = cnt + 2'd1;
                state_n = ENTRY;
            end
        end

        // Derived from the next-state digits so number and bcd update together.
        num_n = 8'(d2_n) * 8'd100 + 8'(d1_n) * 8'd10 + 8'(d0_n);
    end

    assign bus.number = num;
    assign bus.bcd    = {d2, d1, d0};
    assign bus.count  = cnt;
    assign bus.valid  = (state == SHOW);
    assign bus.err    = err_r;

endmodule

// File: tb/tb_decimal_entry.sv
// Directed-vector bench for decimal_entry with hand-computed expected outputs.
module tb_decimal_entry;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    decimal_entry_if bus();

    decimal_entry #(.MAX_DIGITS(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] d, input logic dk, input logic bk,
                         input logic ek, input logic ck);
        bus.digit     = d;
        bus.digit_key = dk;
        bus.back_key  = bk;
        bus.enter_key = ek;
        bus.clear_key = ck;
        tick();
    endtask

    task automatic keys_up();
        bus.digit_key = 1'b0;
        bus.back_key  = 1'b0;
        bus.enter_key = 1'b0;
        bus.clear_key = 1'b0;
        tick();
    endtask

    task automatic key_digit(input logic [3:0] d);
        press(d, 1'b1, 1'b0, 1'b0, 1'b0);
        keys_up();
    endtask

    task automatic key_back();
        press(4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        keys_up();
    endtask

    task automatic key_enter();
        press(4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        keys_up();
    endtask

    task automatic key_clear();
        press(4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        keys_up();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        bus.digit     = 4'd0;
        bus.digit_key = 1'b0;
        bus.back_key  = 1'b0;
        bus.enter_key = 1'b0;
        bus.clear_key = 1'b0;
        reset = 1'b1;
        tick();
        check("rst_number", bus.number, 0);
        check("rst_bcd",    bus.bcd,    0);
        check("rst_count",  bus.count,  0);
        check("rst_valid",  bus.valid,  0);
        check("rst_err",    bus.err,    0);
        reset = 1'b0;
        tick();

        // 1, 2, 8 then commit
        press(4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("d1_count",  bus.count,  1);
        check("d1_number", bus.number, 1);
        keys_up();
        key_digit(4'd2);
        check("d12_count",  bus.count,  2);
        check("d12_number", bus.number, 12);
        key_digit(4'd8);
        check("d128_count",  bus.count,  3);
        check("d128_number", bus.number, 128);
        check("d128_bcd",    bus.bcd,    'h128);
        check("d128_valid",  bus.valid,  0);
        key_enter();
        check("show_valid",  bus.valid,  1);
        check("show_number", bus.number, 128);

        // 256 out of range
        key_clear();
        key_digit(4'd2);
        key_digit(4'd5);
        press(4'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        check("r256_err",    bus.err,    1);
        check("r256_number", bus.number, 25);
        check("r256_count",  bus.count,  2);
        keys_up();
        check("r256_err_end", bus.err,   0);
        key_digit(4'd5);
        check("d255_number", bus.number, 255);
        check("d255_bcd",    bus.bcd,    'h255);

        // fourth digit, then backspace down to empty
        key_clear();
        key_digit(4'd1);
        key_digit(4'd4);
        key_digit(4'd7);
        check("d147_number", bus.number, 147);
        press(4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("d4th_err",    bus.err,    1);
        check("d4th_number", bus.number, 147);
        check("d4th_count",  bus.count,  3);
        keys_up();
        key_back();
        check("bk1_number", bus.number, 14);
        check("bk1_bcd",    bus.bcd,    'h014);
        key_back();
        check("bk2_number", bus.number, 1);
        key_back();
        check("bk3_number", bus.number, 0);
        check("bk3_count",  bus.count,  0);
        press(4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("bk_empty_err", bus.err, 1);
        keys_up();
        press(4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("ent_empty_err",   bus.err,   1);
        check("ent_empty_valid", bus.valid, 0);
        keys_up();

        // held key yields one event; digit > 9 rejected
        bus.digit     = 4'd9;
        bus.digit_key = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check("hold_number", bus.number, 9);
        check("hold_count",  bus.count,  1);
        keys_up();
        press(4'd12, 1'b1, 1'b0, 1'b0, 1'b0);
        check("bad_err",    bus.err,    1);
        check("bad_number", bus.number, 9);
        keys_up();

        // clear beats digit; enter beats back
        press(4'd3, 1'b1, 1'b0, 1'b0, 1'b1);
        check("clr_dig_number", bus.number, 0);
        check("clr_dig_count",  bus.count,  0);
        check("clr_dig_err",    bus.err,    0);
        keys_up();
        key_digit(4'd4);
        key_digit(4'd2);
        press(4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("ent_bk_valid",  bus.valid,  1);
        check("ent_bk_number", bus.number, 42);
        check("ent_bk_err",    bus.err,    0);
        keys_up();
        press(4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("ent_show_err",   bus.err,   0);
        check("ent_show_valid", bus.valid, 1);
        keys_up();

        // leading zero
        key_clear();
        key_digit(4'd0);
        check("lz_count",  bus.count,  1);
        check("lz_number", bus.number, 0);

        // digit from SHOW starts a new entry; back from SHOW keeps digits
        key_clear();
        key_digit(4'd1);
        key_digit(4'd2);
        key_digit(4'd8);
        key_enter();
        key_digit(4'd7);
        check("new_valid",  bus.valid,  0);
        check("new_count",  bus.count,  1);
        check("new_number", bus.number, 7);
        check("new_bcd",    bus.bcd,    'h007);
        key_enter();
        key_back();
        check("shbk_valid",  bus.valid,  0);
        check("shbk_number", bus.number, 7);
        check("shbk_count",  bus.count,  1);

        // reset beats a same-cycle event, then a held key fires after release
        key_digit(4'd5);
        reset = 1'b1;
        press(4'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        check("mid_rst_number", bus.number, 0);
        check("mid_rst_count",  bus.count,  0);
        check("mid_rst_bcd",    bus.bcd,    0);
        check("mid_rst_valid",  bus.valid,  0);
        check("mid_rst_err",    bus.err,    0);
        reset = 1'b0;
        tick();
        check("post_rst_number", bus.number, 6);
        check("post_rst_count",  bus.count,  1);
        keys_up();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
